// File: rtl/dual_issue_scheduler.sv
// Dual-issue in-order scheduler: decodes the two oldest fetched RV32I words,
// tracks in-flight writers with per-register countdowns, and issues 0, 1 or 2
// instructions per cycle into registered lanes.

// Per-lane decode: field extraction, operand usage and scoreboard lookup.
module dis_lane_decode (
  input  logic [31:0] instr,
  input  logic [31:0] busy,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        wr_rd,
  output logic        is_mem,
  output logic        is_ctrl,
  output logic        src_busy
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] op;
  logic       unused_bits;

  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  // funct fields do not affect scheduling
  assign unused_bits = ^{instr[31:25], instr[14:12]};

  // Opcode class table; writes to x0 are never tracked
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    is_mem  = 1'b0;
    is_ctrl = 1'b0;
    case (op)
      OP_R:            begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      OP_I:            begin use_rs1 = 1'b1; wr_rd = 1'b1; end
      OP_LD:           begin use_rs1 = 1'b1; wr_rd = 1'b1; is_mem = 1'b1; end
      OP_ST:           begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; end
      OP_BR:           begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_ctrl = 1'b1; end
      OP_JALR:         begin use_rs1 = 1'b1; wr_rd = 1'b1; is_ctrl = 1'b1; end
      OP_JAL:          begin wr_rd = 1'b1; is_ctrl = 1'b1; end
      OP_LUI, OP_AUIPC: wr_rd = 1'b1;
      default: ;
    endcase
    if (rd == 5'd0) wr_rd = 1'b0;
  end

  assign src_busy = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]);
endmodule

module dual_issue_scheduler #(
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction0,
  input  logic [31:0] instruction1,
  input  logic        nothing_filled,
  input  logic        ex_stall,
  output logic        freeze1,
  output logic        freeze2,
  output logic        dependency_on_ins2,
  output logic        issue0_valid,
  output logic        issue1_valid,
  output logic [31:0] issue0_instr,
  output logic [31:0] issue1_instr,
  output logic [31:0] stall_cycles
);
  localparam int         NUM_LANES = 2;
  localparam logic [2:0] ALU_CNT   = 3'(ALU_LAT);
  localparam logic [2:0] LD_CNT    = 3'(LOAD_LAT);

  logic [NUM_LANES-1:0][31:0] ins;
  logic [NUM_LANES-1:0][4:0]  rd, rs1, rs2;
  logic [NUM_LANES-1:0]       use1, use2, wr, mem, ctrl, src_busy;
  logic [31:0][2:0]           cnt;
  logic [31:0]                busy;
  logic [2:0]                 lsu_cnt;
  logic                       lsu_busy, pair_valid, ins1_present;
  logic                       hz0, hz1, raw, waw, iss0, iss1;

  assign ins = {instruction1, instruction0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dis_lane_decode u_dec (
      .instr   (ins[g]),
      .busy    (busy),
      .rd      (rd[g]),
      .rs1     (rs1[g]),
      .rs2     (rs2[g]),
      .use_rs1 (use1[g]),
      .use_rs2 (use2[g]),
      .wr_rd   (wr[g]),
      .is_mem  (mem[g]),
      .is_ctrl (ctrl[g]),
      .src_busy(src_busy[g])
    );
  end

  // A register is busy while its countdown is nonzero; x0 is always ready
  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (cnt[r] != 3'd0);
  end

  assign lsu_busy     = (lsu_cnt != 3'd0);
  assign pair_valid   = !nothing_filled && (instruction0 != 32'd0);
  assign ins1_present = (instruction1 != 32'd0);

  assign raw = wr[0] && ((use1[1] && rd[0] == rs1[1]) || (use2[1] && rd[0] == rs2[1]));
  assign waw = wr[0] && wr[1] && (rd[0] == rd[1]);
  assign hz0 = src_busy[0] || (mem[0] && lsu_busy);
  // Lane 1 also waits behind any control op in lane 0 (no issue past a branch)
  assign hz1 = !ins1_present || src_busy[1] || raw || waw || (mem[0] && mem[1]) ||
               (mem[1] && lsu_busy) || ctrl[0];

  assign freeze2            = pair_valid && ex_stall;
  assign freeze1            = pair_valid && (ex_stall || hz0);
  assign dependency_on_ins2 = pair_valid && !freeze1 && hz1 && ins1_present;
  assign iss0               = pair_valid && !freeze1;
  assign iss1               = iss0 && !hz1;

  // Scoreboard: issuing writer reloads its rd, everything else counts down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (iss0 && wr[0] && rd[0] == 5'(r))      cnt[r] <= mem[0] ? LD_CNT : ALU_CNT;
        else if (iss1 && wr[1] && rd[1] == 5'(r)) cnt[r] <= mem[1] ? LD_CNT : ALU_CNT;
        else if (cnt[r] != 3'd0)                  cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  // LSU occupancy after a memory op issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 lsu_cnt <= '0;
    else if ((iss0 && mem[0]) || (iss1 && mem[1])) lsu_cnt <= LD_CNT;
    else if (lsu_busy)                       lsu_cnt <= lsu_cnt - 3'd1;
  end

  // Issue lanes; held as-is under execute back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue0_valid <= 1'b0;
      issue1_valid <= 1'b0;
      issue0_instr <= '0;
      issue1_instr <= '0;
    end else if (!ex_stall) begin
      issue0_valid <= iss0;
      issue1_valid <= iss1;
      issue0_instr <= iss0 ? instruction0 : 32'd0;
      issue1_instr <= iss1 ? instruction1 : 32'd0;
    end
  end

  // Saturating count of cycles where instruction0 was held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   stall_cycles <= '0;
    else if (freeze1 && stall_cycles != '1)    stall_cycles <= stall_cycles + 32'd1;
  end
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios then random traffic,
// checked against a ready-time model of the register file and LSU.
module tb_dual_issue_scheduler;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction0 = '0, instruction1 = '0;
  logic        nothing_filled = 1'b1, ex_stall = 1'b0;
  logic        freeze1, freeze2, dependency_on_ins2;
  logic        issue0_valid, issue1_valid;
  logic [31:0] issue0_instr, issue1_instr, stall_cycles;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .instruction0(instruction0), .instruction1(instruction1),
    .nothing_filled(nothing_filled), .ex_stall(ex_stall), .freeze1(freeze1),
    .freeze2(freeze2), .dependency_on_ins2(dependency_on_ins2),
    .issue0_valid(issue0_valid), .issue1_valid(issue1_valid),
    .issue0_instr(issue0_instr), .issue1_instr(issue1_instr), .stall_cycles(stall_cycles)
  );

  // Model: time counted in edges; a register/LSU is free once cyc reaches its ready time
  int unsigned cyc = 0;
  int unsigned ready [32];
  int unsigned lsu_free = 0;
  logic [31:0] m_stall = '0, m_i0 = '0, m_i1 = '0;
  logic        m_v0 = 1'b0, m_v1 = 1'b0;
  logic        e_f1, e_f2, e_dep, e_is0, e_is1;
  int          errors = 0, checks = 0;
  logic [6:0]  ops [0:9];
  logic [31:0] base;

  function automatic logic rs1_used(input logic [31:0] w);
    return w[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction
  function automatic logic rs2_used(input logic [31:0] w);
    return w[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic logic writes(input logic [31:0] w);
    return (w[11:7] != 5'd0) &&
           (w[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111});
  endfunction
  function automatic logic is_mem(input logic [31:0] w);
    return w[6:0] inside {7'b0000011, 7'b0100011};
  endfunction
  function automatic logic is_ctrl(input logic [31:0] w);
    return w[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction
  function automatic logic reg_busy(input logic [4:0] r);
    return (r != 5'd0) && (cyc < ready[r]);
  endfunction
  function automatic logic srcs_busy(input logic [31:0] w);
    return (rs1_used(w) && reg_busy(w[19:15])) || (rs2_used(w) && reg_busy(w[24:20]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic pv, p1, lb, h0, h1;
    logic [31:0] a, b;
    a  = instruction0;
    b  = instruction1;
    pv = !nothing_filled && a != 0;
    p1 = b != 0;
    lb = cyc < lsu_free;
    h0 = srcs_busy(a) || (is_mem(a) && lb);
    h1 = !p1 || srcs_busy(b) ||
         (writes(a) && ((rs1_used(b) && a[11:7] == b[19:15]) || (rs2_used(b) && a[11:7] == b[24:20]))) ||
         (writes(a) && writes(b) && a[11:7] == b[11:7]) ||
         (is_mem(a) && is_mem(b)) || (is_mem(b) && lb) || is_ctrl(a);
    e_f2  = pv && ex_stall;
    e_f1  = pv && (ex_stall || h0);
    e_dep = pv && !e_f1 && h1 && p1;
    e_is0 = pv && !e_f1;
    e_is1 = e_is0 && !h1;
  endtask

  task automatic model_edge();
    cyc++;
    if (!ex_stall) begin
      m_v0 = e_is0; m_i0 = e_is0 ? instruction0 : 32'd0;
      m_v1 = e_is1; m_i1 = e_is1 ? instruction1 : 32'd0;
    end
    if (e_is0 && writes(instruction0))
      ready[instruction0[11:7]] = cyc + (is_mem(instruction0) ? LOAD_LAT : ALU_LAT);
    if (e_is1 && writes(instruction1))
      ready[instruction1[11:7]] = cyc + (is_mem(instruction1) ? LOAD_LAT : ALU_LAT);
    if ((e_is0 && is_mem(instruction0)) || (e_is1 && is_mem(instruction1)))
      lsu_free = cyc + LOAD_LAT;
    if (e_f1 && m_stall != 32'hFFFF_FFFF) m_stall++;
  endtask

  task automatic check_regs();
    chk("issue0_valid", 32'(issue0_valid), 32'(m_v0));
    chk("issue0_instr", issue0_instr, m_i0);
    chk("issue1_valid", 32'(issue1_valid), 32'(m_v1));
    chk("issue1_instr", issue1_instr, m_i1);
    chk("stall_cycles", stall_cycles, m_stall);
  endtask

  // One clock: starts just after a negedge with inputs already driven
  task automatic cycle();
    #1;
    model_eval();
    chk("freeze1", 32'(freeze1), 32'(e_f1));
    chk("freeze2", 32'(freeze2), 32'(e_f2));
    chk("dependency_on_ins2", 32'(dependency_on_ins2), 32'(e_dep));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic nf, input logic es);
    instruction0 = a; instruction1 = b; nothing_filled = nf; ex_stall = es;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int r = 0; r < 32; r++) ready[r] = 0;
    lsu_free = 0; m_stall = '0; m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0;
    check_regs();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};
    for (int r = 0; r < 32; r++) ready[r] = 0;
    @(negedge clk);
    do_reset();

    // independent pair dual-issues
    drive(32'h00100093, 32'h00200113, 0, 0);
    cycle();
    chk("pair_i0", issue0_instr, 32'h00100093);
    chk("pair_i1", issue1_instr, 32'h00200113);
    drive(0, 0, 1, 0); cycle();

    // intra-pair RAW: lane 0 only, then the add waits one ALU cycle
    drive(32'h00100093, 32'h00108133, 0, 0);
    cycle();
    chk("raw_v1", 32'(issue1_valid), 32'd0);
    drive(32'h00108133, 0, 0, 0);
    cycle(); cycle();
    chk("raw_late_i0", issue0_instr, 32'h00108133);
    drive(0, 0, 1, 0); cycle(); cycle();

    // load-use: three frozen cycles, issue on the fourth edge
    drive(32'h00002283, 0, 0, 0);
    cycle();
    base = m_stall;
    drive(32'h00028333, 0, 0, 0);
    repeat (4) cycle();
    chk("ldu_i0", issue0_instr, 32'h00028333);
    chk("ldu_stall", stall_cycles, base + 32'd3);

    // back-pressure holds the issue registers
    drive(32'h00100093, 32'h00200113, 0, 0);
    cycle();
    drive(32'h00400213, 32'h00500293, 0, 1);
    cycle();
    chk("stall_hold_i0", issue0_instr, 32'h00100093);
    chk("stall_hold_i1", issue1_instr, 32'h00200113);

    // empty fetch buffer
    drive(32'h00400213, 32'h00500293, 1, 0);
    cycle();
    chk("empty_v0", 32'(issue0_valid), 32'd0);
    cycle(); cycle();

    // reset in the middle of a load-use freeze
    drive(32'h00002283, 0, 0, 0);
    cycle();
    drive(32'h00028333, 0, 0, 0);
    cycle();
    do_reset();
    cycle();
    chk("rst_ldu_i0", issue0_instr, 32'h00028333);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
           5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
      b = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
           5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
      if ($urandom_range(0, 11) == 0) a = '0;
      if ($urandom_range(0, 5) == 0)  b = '0;
      drive(a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
